// File: rtl/shake_input_loader.sv
// SHAKE input front-end: captures a header word, then packs streamed message
// words into rate-sized blocks handed to the absorb stage over valid/ready.
module shake_input_loader #(
   parameter int W             = 64,
   parameter int LEN_W         = 24,
   parameter int RATE128_WORDS = 21,
   parameter int RATE256_WORDS = 17,
   parameter int RATE_MAX      = 21
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid_in,
   input  logic [W-1:0]                    data_in,
   output logic                            ready_out,
   output logic                            ctrl_valid,
   output logic                            mode_out,
   output logic [LEN_W-1:0]                output_len_out,
   output logic [RATE_MAX*W-1:0]           block_data,
   output logic [$clog2(RATE_MAX+1)-1:0]   block_words,
   output logic                            block_last,
   output logic                            block_valid,
   input  logic                            block_ready
);

   localparam int CW = $clog2(RATE_MAX+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                 state_r, state_n;
   logic                   mode_r, mode_n;
   logic [LEN_W-1:0]       olen_r, olen_n;
   logic [CW-1:0]          rate_r, rate_n;
   logic [LEN_W-1:0]       rem_r, rem_n;
   logic [CW-1:0]          cnt_r, cnt_n;
   logic [CW-1:0]          words_r, words_n;
   logic                   last_r, last_n;
   logic                   ctrl_r, ctrl_n;
   logic                   bvalid_r, bvalid_n;
   logic                   ready_r, ready_n;
   logic [RATE_MAX*W-1:0]  data_r;
   logic                   accept_s, take_s, clear_s, wr_s;
   logic                   unused_hdr_bits_s;

   assign accept_s          = valid_in & ready_r;
   assign take_s            = bvalid_r & block_ready;
   assign unused_hdr_bits_s = ^data_in[W-2:2*LEN_W];

   // Next-state and next-value logic for the control FSM and block metadata.
   always_comb begin
      state_n  = state_r;
      mode_n   = mode_r;
      olen_n   = olen_r;
      rate_n   = rate_r;
      rem_n    = rem_r;
      cnt_n    = cnt_r;
      words_n  = words_r;
      last_n   = last_r;
      ctrl_n   = 1'b0;
      bvalid_n = bvalid_r;
      clear_s  = 1'b0;
      wr_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               mode_n  = data_in[W-1];
               olen_n  = data_in[2*LEN_W-1:LEN_W];
               rate_n  = data_in[W-1] ? CW'(RATE256_WORDS) : CW'(RATE128_WORDS);
               rem_n   = data_in[LEN_W-1:0];
               ctrl_n  = 1'b1;
               clear_s = 1'b1;
               cnt_n   = {CW{1'b0}};
               words_n = {CW{1'b0}};
               if (data_in[LEN_W-1:0] == {LEN_W{1'b0}}) begin
                  state_n  = HOLD;
                  last_n   = 1'b1;
                  bvalid_n = 1'b1;
               end else begin
                  state_n  = FILL;
                  last_n   = 1'b0;
                  bvalid_n = 1'b0;
               end
            end else begin
               state_n = IDLE;
            end
         end
         FILL: begin
            if (accept_s) begin
               wr_s  = 1'b1;
               cnt_n = cnt_r + CW'(1);
               rem_n = rem_r - LEN_W'(1);
               // A full block wins over end-of-message; the pad goes in an extra empty block.
               if ((cnt_r + CW'(1)) == rate_r) begin
                  state_n  = HOLD;
                  words_n  = rate_r;
                  last_n   = 1'b0;
                  bvalid_n = 1'b1;
               end else if (rem_r == LEN_W'(1)) begin
                  state_n  = HOLD;
                  words_n  = cnt_r + CW'(1);
                  last_n   = 1'b1;
                  bvalid_n = 1'b1;
               end else begin
                  state_n = FILL;
               end
            end else begin
               state_n = FILL;
            end
         end
         HOLD: begin
            if (take_s) begin
               bvalid_n = 1'b0;
               if (last_r) begin
                  state_n = IDLE;
               end else if (rem_r == {LEN_W{1'b0}}) begin
                  clear_s = 1'b1;
                  words_n = {CW{1'b0}};
                  last_n  = 1'b1;
                  state_n = HOLD;
               end else begin
                  clear_s = 1'b1;
                  cnt_n   = {CW{1'b0}};
                  state_n = FILL;
               end
            end else if (!bvalid_r) begin
               bvalid_n = 1'b1;
            end else begin
               bvalid_n = 1'b1;
            end
         end
         default: begin
            state_n  = IDLE;
            bvalid_n = 1'b0;
         end
      endcase
      ready_n = (state_n != HOLD);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Header fields, counters and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r   <= 1'b0;
         olen_r   <= {LEN_W{1'b0}};
         rate_r   <= {CW{1'b0}};
         rem_r    <= {LEN_W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         words_r  <= {CW{1'b0}};
         last_r   <= 1'b0;
         ctrl_r   <= 1'b0;
         bvalid_r <= 1'b0;
         ready_r  <= 1'b0;
      end else begin
         mode_r   <= mode_n;
         olen_r   <= olen_n;
         rate_r   <= rate_n;
         rem_r    <= rem_n;
         cnt_r    <= cnt_n;
         words_r  <= words_n;
         last_r   <= last_n;
         ctrl_r   <= ctrl_n;
         bvalid_r <= bvalid_n;
         ready_r  <= ready_n;
      end
   end

   // Block storage: cleared per block so unused word slots read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= {(RATE_MAX*W){1'b0}};
      end else if (clear_s) begin
         data_r <= {(RATE_MAX*W){1'b0}};
      end else if (wr_s) begin
         for (int i = 0; i < RATE_MAX; i++) begin
            if (cnt_r == CW'(i)) begin
               data_r[i*W +: W] <= data_in;
            end
         end
      end
   end

   assign ready_out      = ready_r;
   assign ctrl_valid     = ctrl_r;
   assign mode_out       = mode_r;
   assign output_len_out = olen_r;
   assign block_data     = data_r;
   assign block_words    = words_r;
   assign block_last     = last_r;
   assign block_valid    = bvalid_r;

endmodule

// File: tb/tb_shake_input_loader.sv
// Directed bench for shake_input_loader: header capture, block packing,
// exact-rate empty block, zero-length message, backpressure and reset.
module tb_shake_input_loader;

   localparam int W  = 64;
   localparam int RM = 21;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic [W-1:0]      data_in = 64'h0;
   logic              ready_out, ctrl_valid, mode_out;
   logic [23:0]       output_len_out;
   logic [RM*W-1:0]   block_data;
   logic [4:0]        block_words;
   logic              block_last, block_valid;
   logic              block_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int ctrl_cnt = 0;
   int seq = 0;
   logic [63:0] sent[$];

   shake_input_loader dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .ctrl_valid(ctrl_valid), .mode_out(mode_out),
      .output_len_out(output_len_out), .block_data(block_data),
      .block_words(block_words), .block_last(block_last),
      .block_valid(block_valid), .block_ready(block_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ctrl_valid) ctrl_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] hdr(input logic mode, input logic [23:0] olen, input logic [23:0] len);
      return {mode, 15'h5a5a, olen, len};
   endfunction

   // Present one word and wait (bounded) until it is accepted.
   task automatic send(input logic [63:0] w);
      int n;
      logic acc;
      n = 0;
      acc = 1'b0;
      valid_in = 1'b1;
      data_in = w;
      while (!acc && n < 50) begin
         acc = ready_out;
         tick();
         n++;
      end
      valid_in = 1'b0;
      chk("send_accept", {63'h0, acc}, 64'h1);
   endtask

   task automatic send_msg(input logic [63:0] w);
      sent.push_back(w);
      send(w);
   endtask

   function automatic logic [63:0] next_word();
      seq++;
      return 64'hC0DE_0000_0000_0000 | 64'(seq * 32'h0101_0101);
   endfunction

   task automatic check_block(input string tag, input int words, input logic last, input int base);
      logic [63:0] exp;
      chk({tag, "_valid"}, {63'h0, block_valid}, 64'h1);
      chk({tag, "_words"}, {59'h0, block_words}, 64'(words));
      chk({tag, "_last"}, {63'h0, block_last}, {63'h0, last});
      for (int i = 0; i < RM; i++) begin
         exp = (i < words) ? sent[base + i] : 64'h0;
         chk($sformatf("%s_w%0d", tag, i), block_data[i*W +: W], exp);
      end
   endtask

   task automatic handshake();
      block_ready = 1'b1;
      tick();
      block_ready = 1'b0;
   endtask

   initial begin
      int base;
      // reset state
      tick(); tick();
      chk("rst_ready", {63'h0, ready_out}, 64'h0);
      chk("rst_bvalid", {63'h0, block_valid}, 64'h0);
      chk("rst_ctrl", {63'h0, ctrl_valid}, 64'h0);
      chk("rst_mode", {63'h0, mode_out}, 64'h0);
      chk("rst_olen", {40'h0, output_len_out}, 64'h0);
      chk("rst_words", {59'h0, block_words}, 64'h0);
      chk("rst_last", {63'h0, block_last}, 64'h0);
      chk("rst_data", {63'h0, |block_data}, 64'h0);
      rst = 1'b0;
      tick(); tick();
      chk("idle_ready", {63'h0, ready_out}, 64'h1);

      // mode 0, len 5, block_ready tied high
      block_ready = 1'b1;
      send(hdr(1'b0, 24'd7, 24'd5));
      chk("t1_ctrl", {63'h0, ctrl_valid}, 64'h1);
      chk("t1_mode", {63'h0, mode_out}, 64'h0);
      chk("t1_olen", {40'h0, output_len_out}, 64'd7);
      base = sent.size();
      for (int k = 0; k < 5; k++) send_msg(next_word());
      check_block("t1", 5, 1'b1, base);
      tick();
      chk("t1_bvalid_drop", {63'h0, block_valid}, 64'h0);
      chk("t1_idle_ready", {63'h0, ready_out}, 64'h1);
      block_ready = 1'b0;

      // mode 1, len 40, with valid_in gaps
      ctrl_cnt = 0;
      send(hdr(1'b1, 24'h123456, 24'd40));
      chk("t2_mode", {63'h0, mode_out}, 64'h1);
      chk("t2_olen", {40'h0, output_len_out}, 64'h123456);
      for (int b = 0; b < 3; b++) begin
         int n;
         n = (b < 2) ? 17 : 6;
         base = sent.size();
         for (int k = 0; k < n; k++) begin
            if (k % 3 == 2) tick();
            send_msg(next_word());
         end
         check_block($sformatf("t2b%0d", b), n, (b == 2), base);
         handshake();
         chk("t2_bvalid_drop", {63'h0, block_valid}, 64'h0);
      end
      chk("t2_ctrl_once", 64'(ctrl_cnt), 64'd1);

      // mode 0, len 21: full block then empty pad-only block
      send(hdr(1'b0, 24'd1, 24'd21));
      base = sent.size();
      for (int k = 0; k < 21; k++) send_msg(next_word());
      check_block("t3a", 21, 1'b0, base);
      handshake();
      chk("t3_gap_bvalid", {63'h0, block_valid}, 64'h0);
      chk("t3_gap_ready", {63'h0, ready_out}, 64'h0);
      tick();
      check_block("t3b", 0, 1'b1, 0);
      chk("t3b_ready", {63'h0, ready_out}, 64'h0);
      handshake();
      chk("t3_end_ready", {63'h0, ready_out}, 64'h1);

      // zero-length message
      send(hdr(1'b0, 24'h00ABCD, 24'd0));
      chk("t4_ctrl", {63'h0, ctrl_valid}, 64'h1);
      chk("t4_olen", {40'h0, output_len_out}, 64'h00ABCD);
      check_block("t4", 0, 1'b1, 0);
      handshake();

      // backpressure: block_ready low for 10 cycles in HOLD
      send(hdr(1'b0, 24'd3, 24'd2));
      base = sent.size();
      for (int k = 0; k < 2; k++) send_msg(next_word());
      valid_in = 1'b1;
      data_in = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t5_ready", {63'h0, ready_out}, 64'h0);
         chk("t5_bvalid", {63'h0, block_valid}, 64'h1);
      end
      valid_in = 1'b0;
      check_block("t5", 2, 1'b1, base);
      handshake();
      chk("t5_idle_ready", {63'h0, ready_out}, 64'h1);

      // reset mid-FILL, then mode 1 len 3
      send(hdr(1'b0, 24'd0, 24'd30));
      for (int k = 0; k < 8; k++) send(64'hBAD0_0000_0000_0000 | 64'(k));
      rst = 1'b1;
      #1;
      chk("t6_rst_ready", {63'h0, ready_out}, 64'h0);
      chk("t6_rst_data", {63'h0, |block_data}, 64'h0);
      tick();
      rst = 1'b0;
      tick(); tick();
      send(hdr(1'b1, 24'd9, 24'd3));
      chk("t6_mode", {63'h0, mode_out}, 64'h1);
      base = sent.size();
      for (int k = 0; k < 3; k++) send_msg(next_word());
      check_block("t6", 3, 1'b1, base);
      handshake();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shake_input_loader.md
Name: shake_input_loader

Overview:
- Parametrised input front-end for the SHAKE core. Captures a header word, then packs streamed message words into one rate-sized block (SIPO) per permutation.
- Supports SHAKE128 and SHAKE256 rates. Tracks remaining input length and flags the last block, including the extra empty block needed when the message ends exactly on a rate boundary.
- Presents each finished block to the absorb/padding stage through a valid/ready handshake.

Parameters:
- W, 64, data word width in bits.
- LEN_W, 24, width of the input/output length fields, in words; 2*LEN_W+1 <= W is required.
- RATE128_WORDS, 21, block size in words for mode 0 (SHAKE128; 1344 bits / W).
- RATE256_WORDS, 17, block size in words for mode 1 (SHAKE256; 1088 bits / W).
- RATE_MAX, 21, max(RATE128_WORDS, RATE256_WORDS); sets storage depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  upstream word valid
- data_in  in  W  header or message word
- ready_out  out  1  word accepted when valid_in & ready_out
- ctrl_valid  out  1  one-cycle pulse when a header is captured
- mode_out  out  1  0=SHAKE128, 1=SHAKE256; held until the next header
- output_len_out  out  LEN_W  requested output length in words; held
- block_data  out  RATE_MAX*W  packed block; word i at [i*W +: W]
- block_words  out  $clog2(RATE_MAX+1)  count of valid words in block (0..rate)
- block_last  out  1  block is the final block of the message
- block_valid  out  1  block available
- block_ready  in  1  consumer takes the block when block_valid & block_ready

Behaviour:
- Reset: state=IDLE. ready_out=0, ctrl_valid=0, mode_out=0, output_len_out=0, block_data=0, block_words=0, block_last=0, block_valid=0, internal counters=0.
- Header word fields: bit W-1 = mode; [LEN_W-1:0] = input length in words (len); [2*LEN_W-1:LEN_W] = output length. Other bits are ignored.
- rate = mode ? RATE256_WORDS : RATE128_WORDS, latched with the header.
- States:
  - IDLE:
    - ready_out=1.
    - On accept: latch mode, output_len and remaining=len; pulse ctrl_valid next cycle; clear block_data and cnt.
    - If len==0, go to HOLD with block_words=0, block_last=1.
    - Otherwise go to FILL.
  - FILL:
    - ready_out=1. On accept: block_data word[cnt] <= data_in; cnt++; remaining--.
    - If the accepted word makes cnt==rate, go to HOLD with block_words=rate and block_last=0. This holds even when remaining reaches 0.
    - Else if remaining reaches 0, go to HOLD with block_words=cnt+1 and block_last=1.
    - valid_in low: hold state; nothing changes.
  - HOLD:
    - block_valid=1 and ready_out=0; block outputs stable.
    - On block_ready, block_valid drops next cycle, then:
      - block_last=1: go to IDLE.
      - remaining==0 and block_last=0 (exact-multiple case): clear block_data; stay in HOLD with block_words=0, block_last=1. This is the empty pad-only block.
      - otherwise: clear block_data, cnt=0, go to FILL.
- Latency: block_valid rises the cycle after the final word of the block is accepted. There is no ready_out bubble after a header.
- Words at indices >= block_words are guaranteed zero.
- block_ready is ignored while block_valid=0. valid_in is ignored while ready_out=0.
- Asynchronous reset mid-block discards all partial data and returns to IDLE.
- Lengths up to 2^LEN_W-1 words are supported; remaining never underflows.

Test Plan:
- Mode 0, len=5, block_ready tied 1 -> one block: block_words=5, block_last=1, words 5..20 zero, words 0..4 equal inputs; then IDLE with ready_out=1.
- Mode 1, len=40, with valid_in gaps -> blocks of 17 (last=0), 17 (last=0), 6 (last=1); ctrl_valid pulses exactly once.
- Mode 0, len=21 -> a 21-word block with last=0, then an empty block with words=0, last=1; ready_out stays 0 between the two blocks.
- len=0 header -> a single block with words=0, last=1 the cycle after the header; output_len_out equals the header field.
- block_ready held low for 10 cycles in HOLD -> ready_out=0, block outputs stable, valid_in words not accepted.
- Reset asserted mid-FILL (cnt=8), then a new mode 1 header with len=3 -> block_words=3, last=1, no residue from the earlier block.
